// File: rtl/seg7_scan_mux_if.sv
// Bundle between the GPIO segment source and the scanned display driver.
// master = GPIO/pattern side, slave = scan mux.
interface seg7_scan_mux_if;
    logic       enable;
    logic [7:0] digit_mask;
    logic [7:0] seg_in_0;
    logic [7:0] seg_in_1;
    logic [7:0] seg_in_2;
    logic [7:0] seg_in_3;
    logic [7:0] seg_in_4;
    logic [7:0] seg_in_5;
    logic [7:0] seg_in_6;
    logic [7:0] seg_in_7;
    logic [7:0] seg_out;
    logic [7:0] an_out;
    logic [2:0] scan_idx;
    logic       frame_done;

    modport master (
        output enable, digit_mask,
        output seg_in_0, seg_in_1, seg_in_2, seg_in_3,
        output seg_in_4, seg_in_5, seg_in_6, seg_in_7,
        input  seg_out, an_out, scan_idx, frame_done
    );

    modport slave (
        input  enable, digit_mask,
        input  seg_in_0, seg_in_1, seg_in_2, seg_in_3,
        input  seg_in_4, seg_in_5, seg_in_6, seg_in_7,
        output seg_out, an_out, scan_idx, frame_done
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Eight-digit 7-seg scanner: BLANK_CYC dark cycles then SHOW_CYC lit cycles per digit.
// Digit 0 lit BLANK_CYC edges after the enabling edge; no backpressure, free-running while enabled.
module seg7_scan_mux #(
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned SHOW_CYC  = 1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic           clock,
    input  logic           reset,
    seg7_scan_mux_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       seg_lat;
    logic [7:0]       seg_lat_nxt;
    logic             frame_done_q;
    logic             frame_done_nxt;
    logic [7:0]       seg_sel;
    logic             digit_lit;

    always_comb begin
        seg_sel = 8'hFF;
        case (idx)
            3'd0:    seg_sel = bus.seg_in_0;
            3'd1:    seg_sel = bus.seg_in_1;
            3'd2:    seg_sel = bus.seg_in_2;
            3'd3:    seg_sel = bus.seg_in_3;
            3'd4:    seg_sel = bus.seg_in_4;
            3'd5:    seg_sel = bus.seg_in_5;
            3'd6:    seg_sel = bus.seg_in_6;
            default: seg_sel = bus.seg_in_7;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= 3'd0;
            seg_lat      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            seg_lat      <= seg_lat_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

    // Enable loss wins over slot completion so the scan always restarts at digit 0.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        seg_lat_nxt    = seg_lat;
        frame_done_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = 3'd0;
                if (bus.enable) begin
                    state_nxt = ST_BLANK;
                end
            end

            ST_BLANK: begin
                if (!bus.enable) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt   = ST_SHOW;
                    cnt_nxt     = '0;
                    seg_lat_nxt = seg_sel;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_SHOW: begin
                if (!bus.enable) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end else if (cnt == SHOW_LAST) begin
                    state_nxt      = ST_BLANK;
                    cnt_nxt        = '0;
                    idx_nxt        = idx + 3'd1;
                    frame_done_nxt = (idx == 3'd7);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // A masked digit still spends its slot, it just stays dark.
    assign digit_lit      = (state == ST_SHOW) && bus.digit_mask[idx];
    assign bus.seg_out    = digit_lit ? seg_lat : 8'hFF;
    assign bus.an_out     = digit_lit ? ~(8'b1 << idx) : 8'hFF;
    assign bus.scan_idx   = idx;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboarded bench for seg7_scan_mux: a frame-position model predicts every cycle's outputs.
module tb_seg7_scan_mux;

    localparam int B = 2;
    localparam int S = 4;
    localparam int P = B + S;
    localparam int F = 8 * P;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic [2:0] idx;
        logic       fd;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seg7_scan_mux_if bus();

    seg7_scan_mux #(.BLANK_CYC(B), .SHOW_CYC(S), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic       d_en;
    logic [7:0] d_mask;
    logic [7:0] d_seg [8];
    logic       n_rst;
    logic       n_en;
    logic [7:0] n_mask;
    logic [7:0] n_seg [8];

    assign bus.enable     = d_en;
    assign bus.digit_mask = d_mask;
    assign bus.seg_in_0   = d_seg[0];
    assign bus.seg_in_1   = d_seg[1];
    assign bus.seg_in_2   = d_seg[2];
    assign bus.seg_in_3   = d_seg[3];
    assign bus.seg_in_4   = d_seg[4];
    assign bus.seg_in_5   = d_seg[5];
    assign bus.seg_in_6   = d_seg[6];
    assign bus.seg_in_7   = d_seg[7];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Model: t counts edges since the scan entered its first blank cycle.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_lat    = 8'hFF;
    logic       m_fd     = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    task automatic model_edge();
        int pos;
        if (reset) begin
            m_active = 1'b0;
            m_lat    = 8'hFF;
            m_fd     = 1'b0;
        end else if (!m_active) begin
            m_fd = 1'b0;
            if (d_en) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (!d_en) begin
            m_active = 1'b0;
            m_fd     = 1'b0;
        end else begin
            m_t++;
            pos = m_t % F;
            if (pos % P == B) m_lat = d_seg[pos / P];
            m_fd = (pos == 0);
        end
    endtask

    task automatic apply_and_push();
        exp_t e;
        int   pos;
        int   dig;
        reset  = n_rst;
        d_en   = n_en;
        d_mask = n_mask;
        for (int i = 0; i < 8; i++) d_seg[i] = n_seg[i];
        e.seg = 8'hFF;
        e.an  = 8'hFF;
        e.idx = 3'd0;
        e.fd  = m_fd;
        if (m_active) begin
            pos   = m_t % F;
            dig   = pos / P;
            e.idx = 3'(dig);
            if ((pos % P) >= B && d_mask[dig]) begin
                e.seg = m_lat;
                e.an  = ~(8'b1 << dig);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        model_edge();
        apply_and_push();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the current cycle sits at frame position tgt.
    task automatic seek(input int tgt);
        int guard;
        guard = 0;
        while (!(m_active && (m_t % F) == tgt)) begin
            cycle();
            guard++;
            if (guard > 3 * F) begin
                n_checks++;
                n_err++;
                $display("FAIL seek: position %0d not reached within %0d cycles", tgt, guard);
                return;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_out",    bus.seg_out,           e.seg);
                chk("an_out",     bus.an_out,            e.an);
                chk("scan_idx",   {5'd0, bus.scan_idx},  {5'd0, e.idx});
                chk("frame_done", {7'd0, bus.frame_done}, {7'd0, e.fd});
            end
        end
    end

    initial begin : driver
        n_rst  = 1'b1;
        n_en   = 1'b1;
        n_mask = 8'hFF;
        for (int i = 0; i < 8; i++) n_seg[i] = 8'($urandom);
        reset  = 1'b1;
        d_en   = 1'b1;
        d_mask = 8'hFF;
        for (int i = 0; i < 8; i++) d_seg[i] = n_seg[i];

        // Reset held with enable high, then released with enable low.
        run(3);
        n_rst = 1'b0;
        n_en  = 1'b0;
        run(3);

        // Full frame with fixed patterns, then one masked frame.
        for (int i = 0; i < 8; i++) n_seg[i] = 8'h10 + 8'(i);
        n_en = 1'b1;
        run(1 + F + 2);
        n_mask = 8'b1010_1010;
        run(F);

        // Latch stability on digit 3.
        n_mask   = 8'hFF;
        n_seg[3] = 8'hC0;
        seek(0);
        seek(3 * P + B);
        n_seg[3] = 8'hF9;
        cycle();
        run(F);

        // Enable drop in digit 5's SHOW, then re-enable.
        seek(5 * P + B + 1);
        n_en = 1'b0;
        cycle();
        run(3);
        n_en = 1'b1;
        run(1 + P + 2);

        // One-cycle reset during digit 6's BLANK with enable kept high.
        seek(6 * P);
        n_rst = 1'b1;
        cycle();
        n_rst = 1'b0;
        run(1 + P + 4);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) n_seg[i] = 8'($urandom);
            if ($urandom_range(0, 19) == 0) n_mask = 8'($urandom);
            n_en  = ($urandom_range(0, 39) != 0);
            n_rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        n_rst = 1'b0;
        n_en  = 1'b1;
        run(F);

        @(negedge clock);
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
